mackey_glass_lut_prog: RTL and testbench

Programmable Mackey-Glass nonlinearity table for the DFR reservoir node: the write side of the nonlinearity lookup. Software streams table values in over a valid/ready configuration port. Once the table is full, the block serves pipelined lookups of reservoir samples and returns the nonlinearity value. It replaces a fixed, synthesized table so the nonlinearity can be retuned at run time without re-synthesis.

---
 rtl/mackey_glass_lut_prog_if.sv | 28 ++
 rtl/mackey_glass_lut_prog.sv | 109 ++++++++++
 tb/tb_mackey_glass_lut_prog.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mackey_glass_lut_prog_if.sv
// Configuration and lookup signal bundle for the programmable Mackey-Glass table.
// The master drives table loads and lookup requests; the slave is the table block.
interface mackey_glass_lut_prog_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cfg_start;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_done;
    logic                  table_loaded;
    logic                  busy;
    logic                  lut_valid_in;
    logic [DATA_WIDTH-1:0] din;
    logic                  lut_valid_out;
    logic [DATA_WIDTH-1:0] dout;
    logic                  lut_drop;

    modport master (
        output cfg_start, cfg_valid, cfg_data, lut_valid_in, din,
        input  cfg_ready, cfg_done, table_loaded, busy, lut_valid_out, dout, lut_drop
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, lut_valid_in, din,
        output cfg_ready, cfg_done, table_loaded, busy, lut_valid_out, dout, lut_drop
    );
endinterface

// File: rtl/mackey_glass_lut_prog.sv
// Run-time programmable Mackey-Glass nonlinearity table: streamed load over valid/ready,
// then two-cycle pipelined lookups of reservoir samples.
module mackey_glass_lut_prog #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 8
) (
    input logic                    clk,
    input logic                    rst,
    mackey_glass_lut_prog_if.slave bus
);
    localparam int unsigned ENTRIES = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StLoad, StActive} state_e;

    state_e                state_q;
    logic [ADDR_BITS-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] mem [ENTRIES];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  v1_q;
    logic                  oor1_q;
    logic                  cfg_ready_q;
    logic                  cfg_done_q;
    logic                  busy_q;
    logic                  table_loaded_q;
    logic                  valid_out_q;
    logic                  drop_q;
    logic [DATA_WIDTH-1:0] dout_q;

    logic                 in_range;
    logic                 accept;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] rd_idx;

    assign in_range = (bus.din[DATA_WIDTH-1:16] == '0);
    assign rd_idx   = bus.din[15 -: ADDR_BITS];
    assign accept   = bus.lut_valid_in && (state_q == StActive);
    // A start pulse restarts the load, so a coincident entry is discarded.
    assign wr_en    = (state_q == StLoad) && bus.cfg_valid && !bus.cfg_start && !rst;

    // Single write port, registered read port; the read only ever happens in
    // ACTIVE, so an in-flight request always sees the previous table.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt_q] <= bus.cfg_data;
        end
        if (accept && in_range) begin
            rd_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            cfg_ready_q    <= 1'b0;
            cfg_done_q     <= 1'b0;
            busy_q         <= 1'b0;
            table_loaded_q <= 1'b0;
            v1_q           <= 1'b0;
            oor1_q         <= 1'b0;
            valid_out_q    <= 1'b0;
            drop_q         <= 1'b0;
            dout_q         <= '0;
        end else begin
            cfg_done_q  <= 1'b0;
            drop_q      <= bus.lut_valid_in && (state_q != StActive);
            v1_q        <= accept;
            oor1_q      <= !in_range;
            valid_out_q <= v1_q;
            if (v1_q) begin
                dout_q <= oor1_q ? '0 : rd_q;
            end
            unique case (state_q)
                StIdle, StActive: begin
                    if (bus.cfg_start) begin
                        state_q        <= StLoad;
                        cnt_q          <= '0;
                        busy_q         <= 1'b1;
                        cfg_ready_q    <= 1'b1;
                        table_loaded_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (bus.cfg_start) begin
                        cnt_q <= '0;
                    end else if (bus.cfg_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == ADDR_BITS'(ENTRIES - 1)) begin
                            state_q        <= StActive;
                            cfg_done_q     <= 1'b1;
                            table_loaded_q <= 1'b1;
                            busy_q         <= 1'b0;
                            cfg_ready_q    <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cfg_ready     = cfg_ready_q;
    assign bus.cfg_done      = cfg_done_q;
    assign bus.busy          = busy_q;
    assign bus.table_loaded  = table_loaded_q;
    assign bus.lut_valid_out = valid_out_q;
    assign bus.dout          = dout_q;
    assign bus.lut_drop      = drop_q;
endmodule

// File: tb/tb_mackey_glass_lut_prog.sv
// Directed-plus-random bench for mackey_glass_lut_prog; lookups are checked against a
// table model holding the contents of the last complete load.
module tb_mackey_glass_lut_prog;
    logic clk;
    logic rst;

    mackey_glass_lut_prog_if #(.DATA_WIDTH(32)) bus ();

    mackey_glass_lut_prog #(
        .DATA_WIDTH(32),
        .ADDR_BITS (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mdl [256];
    logic [31:0] vals [256];
    logic [31:0] exp_dout = '0;
    logic [31:0] req_d [$];
    bit          req_v [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_lut(input logic [31:0] d);
        logic [7:0] idx;
        idx = d[15:8];
        if (d[31:16] != 16'h0) return 32'h0;
        return mdl[idx];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, ".cfg_ready"}, {31'b0, bus.cfg_ready}, 32'd0);
        check({tag, ".cfg_done"}, {31'b0, bus.cfg_done}, 32'd0);
        check({tag, ".busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, ".table_loaded"}, {31'b0, bus.table_loaded}, 32'd0);
        check({tag, ".lut_valid_out"}, {31'b0, bus.lut_valid_out}, 32'd0);
        check({tag, ".lut_drop"}, {31'b0, bus.lut_drop}, 32'd0);
        check({tag, ".dout"}, bus.dout, 32'd0);
    endtask

    // Request outside ACTIVE: dropped one cycle later, never returned.
    task automatic drop_check(input string tag, input logic [31:0] d);
        bus.lut_valid_in = 1'b1;
        bus.din          = d;
        tick();
        bus.lut_valid_in = 1'b0;
        check({tag, ".drop_pulse"}, {31'b0, bus.lut_drop}, 32'd1);
        check({tag, ".no_valid0"}, {31'b0, bus.lut_valid_out}, 32'd0);
        tick();
        check({tag, ".drop_end"}, {31'b0, bus.lut_drop}, 32'd0);
        check({tag, ".no_valid1"}, {31'b0, bus.lut_valid_out}, 32'd0);
        tick();
        check({tag, ".no_valid2"}, {31'b0, bus.lut_valid_out}, 32'd0);
        check({tag, ".dout_hold"}, bus.dout, exp_dout);
    endtask

    // Drives req_d/req_v on consecutive cycles in ACTIVE and checks every output cycle.
    task automatic run_reqs(input string tag);
        int n;
        n = req_d.size();
        for (int t = 0; t <= n + 1; t++) begin
            if (t < n) begin
                bus.lut_valid_in = req_v[t];
                bus.din          = req_d[t];
            end else begin
                bus.lut_valid_in = 1'b0;
            end
            tick();
            if (t >= 1 && t - 1 < n && req_v[t-1]) begin
                exp_dout = ref_lut(req_d[t-1]);
                check({tag, ".valid"}, {31'b0, bus.lut_valid_out}, 32'd1);
            end else begin
                check({tag, ".novalid"}, {31'b0, bus.lut_valid_out}, 32'd0);
            end
            check({tag, ".dout"}, bus.dout, exp_dout);
            check({tag, ".drop"}, {31'b0, bus.lut_drop}, 32'd0);
        end
        req_d.delete();
        req_v.delete();
    endtask

    task automatic one_lookup(input string tag, input logic [31:0] d, input logic [31:0] want);
        check({tag, ".model"}, ref_lut(d), want);
        req_d.push_back(d);
        req_v.push_back(1'b1);
        run_reqs(tag);
    endtask

    task automatic random_burst(input string tag, input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = {16'h0, 16'($urandom)};
            if ($urandom_range(0, 3) == 0) d[31:16] = 16'($urandom_range(1, 16'hFFFF));
            req_d.push_back(d);
            req_v.push_back($urandom_range(0, 3) != 0);
        end
        run_reqs(tag);
    endtask

    // Start pulse with a junk entry alongside it, which must be ignored.
    task automatic start_load(input string tag);
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 32'hDEAD_BEEF;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        check({tag, ".busy"}, {31'b0, bus.busy}, 32'd1);
        check({tag, ".cfg_ready"}, {31'b0, bus.cfg_ready}, 32'd1);
        check({tag, ".loaded_clr"}, {31'b0, bus.table_loaded}, 32'd0);
    endtask

    task automatic write_entries(input int n, input bit gaps, output int done_cnt);
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 3 && gaps && $urandom_range(0, 2) == 0; g++) begin
                bus.cfg_valid = 1'b0;
                bus.cfg_data  = $urandom;
                tick();
                if (bus.cfg_done) done_cnt++;
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = vals[i];
            tick();
            if (bus.cfg_done) done_cnt++;
        end
        bus.cfg_valid = 1'b0;
    endtask

    // Called right after the last handshake of a complete load.
    task automatic finish_load(input string tag, input int done_cnt);
        int dc;
        dc = done_cnt;
        check({tag, ".done_now"}, {31'b0, bus.cfg_done}, 32'd1);
        check({tag, ".loaded"}, {31'b0, bus.table_loaded}, 32'd1);
        check({tag, ".busy_off"}, {31'b0, bus.busy}, 32'd0);
        check({tag, ".ready_off"}, {31'b0, bus.cfg_ready}, 32'd0);
        tick();
        if (bus.cfg_done) dc++;
        check({tag, ".done_once"}, dc, 32'd1);
        for (int i = 0; i < 256; i++) mdl[i] = vals[i];
    endtask

    initial begin
        int dc;
        logic [31:0] d;
        rst              = 1'b1;
        bus.cfg_start    = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_data     = '0;
        bus.lut_valid_in = 1'b0;
        bus.din          = '0;
        for (int i = 0; i < 256; i++) mdl[i] = 32'hX;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");
        tick();
        check_idle_outputs("reset_idle");
        drop_check("idle_drop", 32'h0000_1234);

        // Continuous load of i*16.
        start_load("load0");
        for (int i = 0; i < 256; i++) vals[i] = 32'(i * 16);
        write_entries(256, 1'b0, dc);
        finish_load("load0", dc);
        one_lookup("lk_1234", 32'h0000_1234, 32'h0000_0120);
        one_lookup("lk_ffff", 32'h0000_FFFF, 32'h0000_0FF0);
        one_lookup("lk_oor", 32'h0001_0000, 32'h0000_0000);
        random_burst("burst0", 40);

        // Lookup coincident with a reload start completes against the old table.
        d                = {16'h0, 16'($urandom)};
        bus.lut_valid_in = 1'b1;
        bus.din          = d;
        bus.cfg_start    = 1'b1;
        tick();
        bus.lut_valid_in = 1'b0;
        bus.cfg_start    = 1'b0;
        check("inflight.drop", {31'b0, bus.lut_drop}, 32'd0);
        check("inflight.busy", {31'b0, bus.busy}, 32'd1);
        check("inflight.loaded_clr", {31'b0, bus.table_loaded}, 32'd0);
        tick();
        exp_dout = ref_lut(d);
        check("inflight.valid", {31'b0, bus.lut_valid_out}, 32'd1);
        check("inflight.dout", bus.dout, exp_dout);
        drop_check("load_drop", 32'h0000_0500);

        // Partial junk load, then restart with a full gapped load of 0xA000+i.
        for (int i = 0; i < 256; i++) vals[i] = $urandom;
        write_entries(101, 1'b1, dc);
        check("partial.no_done", dc, 32'd0);
        check("partial.not_loaded", {31'b0, bus.table_loaded}, 32'd0);
        start_load("restart");
        for (int i = 0; i < 256; i++) vals[i] = 32'hA000 + 32'(i);
        write_entries(256, 1'b1, dc);
        finish_load("load1", dc);
        one_lookup("lk_0500", 32'h0000_0500, 32'h0000_A005);

        req_d.push_back(32'h0000_0000); req_v.push_back(1'b1);
        req_d.push_back(32'h0000_0100); req_v.push_back(1'b1);
        req_d.push_back(32'h0000_0200); req_v.push_back(1'b1);
        run_reqs("b2b");
        check("b2b.last", bus.dout, 32'h0000_A002);
        random_burst("burst1", 40);

        // Reset with a lookup in flight: no valid, no drop.
        bus.lut_valid_in = 1'b1;
        bus.din          = 32'h0000_0300;
        tick();
        bus.lut_valid_in = 1'b0;
        rst              = 1'b1;
        tick();
        rst      = 1'b0;
        exp_dout = '0;
        check_idle_outputs("rst_lookup");
        tick();
        check("rst_lookup.no_valid", {31'b0, bus.lut_valid_out}, 32'd0);
        check("rst_lookup.no_drop", {31'b0, bus.lut_drop}, 32'd0);

        // Reset after 50 entries of a load.
        start_load("load2");
        for (int i = 0; i < 256; i++) vals[i] = $urandom;
        write_entries(50, 1'b1, dc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rst_load");
        drop_check("rst_drop", 32'h0000_1234);
        start_load("load3");
        write_entries(256, 1'b1, dc);
        finish_load("load3", dc);
        random_burst("burst2", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
